// File: rtl/demux_1_n_stream.sv
// Registered 1:N stream demultiplexer with per-channel one-entry output registers.
// Optional per-channel saturating beat counters are built when DEMUX_BEAT_COUNT_EN is defined.
module demux_1_n_stream #(
    parameter int NUM_CH = 32,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                     Clock_In,
    input  logic                     Reset_In,
    input  logic                     Enable_In,
    input  logic                     Valid_In,
    output logic                     Ready_Out,
    input  logic [DATA_W-1:0]        Data_In,
    input  logic [SEL_W-1:0]         Select_In,
    output logic [NUM_CH-1:0]        Valid_Out,
    input  logic [NUM_CH-1:0]        Ready_In,
    output logic [NUM_CH*DATA_W-1:0] Data_Out,
    output logic                     Error_Out,
    input  logic [SEL_W-1:0]         Count_Select_In,
    output logic [CNT_W-1:0]         Count_Out
);

    logic [NUM_CH-1:0]        sel_oh;
    logic                     sel_in_range;
    logic                     accept;
    logic [NUM_CH-1:0]        vld_p1;
    logic [NUM_CH*DATA_W-1:0] data_p1;
    logic                     err_p1;

    // An out-of-range select decodes to no channel, so it can never be blocked.
    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_oh[k] = (int'(Select_In) == k);
        end
    end

    assign sel_in_range = (int'(Select_In) < NUM_CH);
    assign Ready_Out    = !Reset_In && Enable_In && !(|(sel_oh & vld_p1 & ~Ready_In));
    assign accept       = Valid_In && Ready_Out;

    // Stage p1: channel output registers
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            vld_p1  <= '0;
            data_p1 <= '0;
            err_p1  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (accept && sel_oh[k]) begin
                    vld_p1[k]                   <= 1'b1;
                    data_p1[k*DATA_W +: DATA_W] <= Data_In;
                end else if (Ready_In[k]) begin
                    vld_p1[k] <= 1'b0;
                end
            end
            err_p1 <= accept && !sel_in_range;
        end
    end

    assign Valid_Out = vld_p1;
    assign Data_Out  = data_p1;
    assign Error_Out = err_p1;

`ifdef DEMUX_BEAT_COUNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] cnt_p1 [NUM_CH];
    logic [CNT_W-1:0] cnt_mux;
    logic [CNT_W-1:0] count_p2;

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            for (int k = 0; k < NUM_CH; k++) cnt_p1[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (accept && sel_oh[k]) cnt_p1[k] <= sat_inc(cnt_p1[k]);
            end
        end
    end

    always_comb begin
        cnt_mux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(Count_Select_In) == k) cnt_mux = cnt_p1[k];
        end
    end

    // Stage p2: registered counter readout
    always_ff @(posedge Clock_In) begin
        if (Reset_In) count_p2 <= '0;
        else          count_p2 <= cnt_mux;
    end

    assign Count_Out = count_p2;
`else
    logic unused_count_sel;
    assign unused_count_sel = ^Count_Select_In;
    assign Count_Out        = '0;
`endif

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Directed bench for demux_1_n_stream: a 32-channel and a 24-channel instance share stimulus.
// Counter expectations follow DEMUX_BEAT_COUNT_EN (CNT_W=4 on both instances).
module tb_demux_1_n_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DEMUX_BEAT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         rst, en, vin;
    logic [4:0]   sel, csel;
    logic [7:0]   din;
    logic [31:0]  rdy;

    logic         rdy_o, err;
    logic [31:0]  vout;
    logic [255:0] dout;
    logic [3:0]   cnt;

    logic         rdy_o24, err24;
    logic [23:0]  vout24;
    logic [191:0] dout24;
    logic [3:0]   cnt24;

    int n_cmp = 0;
    int n_err = 0;

    demux_1_n_stream #(.NUM_CH(32), .DATA_W(8), .CNT_W(4)) dut (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Valid_In(vin),
        .Ready_Out(rdy_o), .Data_In(din), .Select_In(sel), .Valid_Out(vout),
        .Ready_In(rdy), .Data_Out(dout), .Error_Out(err),
        .Count_Select_In(csel), .Count_Out(cnt)
    );

    demux_1_n_stream #(.NUM_CH(24), .DATA_W(8), .CNT_W(4)) dut24 (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Valid_In(vin),
        .Ready_Out(rdy_o24), .Data_In(din), .Select_In(sel), .Valid_Out(vout24),
        .Ready_In(rdy[23:0]), .Data_Out(dout24), .Error_Out(err24),
        .Count_Select_In(csel), .Count_Out(cnt24)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] cexp(input int n);
        if (!CNT_EN) return 4'd0;
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; vin = 1'b0; sel = '0; din = '0; rdy = '1; csel = 5'd2;
        tick();
        tick();
        chk("reset_ready", {63'd0, rdy_o}, 64'd0);
        chk("reset_vout", {32'd0, vout}, 64'd0);
        chk("reset_dout", dout[63:0], 64'd0);
        chk("reset_err", {63'd0, err}, 64'd0);
        chk("reset_cnt", {60'd0, cnt}, 64'd0);

        // 1: single beat to channel 5
        rst = 1'b0; en = 1'b1; vin = 1'b1; sel = 5'd5; din = 8'hA5;
        #1 chk("t1_ready", {63'd0, rdy_o}, 64'd1);
        tick();
        chk("t1_vout", {32'd0, vout}, 64'h20);
        chk("t1_data", {56'd0, dout[47:40]}, 64'hA5);
        vin = 1'b0;
        tick();
        chk("t1_drained", {32'd0, vout}, 64'd0);

        // 2: backpressure on channel 3
        rdy[3] = 1'b0; vin = 1'b1; sel = 5'd3; din = 8'h11;
        #1 chk("t2_ready_first", {63'd0, rdy_o}, 64'd1);
        tick();
        chk("t2_v3", {63'd0, vout[3]}, 64'd1);
        chk("t2_d3", {56'd0, dout[31:24]}, 64'h11);
        din = 8'h22;
        #1 chk("t2_ready_stalled", {63'd0, rdy_o}, 64'd0);
        tick();
        chk("t2_hold_v3", {63'd0, vout[3]}, 64'd1);
        chk("t2_hold_d3", {56'd0, dout[31:24]}, 64'h11);
        sel = 5'd7;
        #1 chk("t2_ready_ch7", {63'd0, rdy_o}, 64'd1);
        tick();
        chk("t2_vout_37", {32'd0, vout}, 64'h88);
        chk("t2_d7", {56'd0, dout[63:56]}, 64'h22);
        chk("t2_still_d3", {56'd0, dout[31:24]}, 64'h11);
        rdy[3] = 1'b1; sel = 5'd3;
        #1 chk("t2_ready_drain_load", {63'd0, rdy_o}, 64'd1);
        tick();
        chk("t2_vout_reload", {32'd0, vout}, 64'h08);
        chk("t2_d3_new", {56'd0, dout[31:24]}, 64'h22);
        vin = 1'b0;
        tick();
        chk("t2_empty", {32'd0, vout}, 64'd0);

        // 3: back-to-back beats across all 32 channels
        vin = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sel = 5'(i); din = 8'(i);
            #1 chk($sformatf("t3_ready_%0d", i), {63'd0, rdy_o}, 64'd1);
            tick();
            chk($sformatf("t3_vout_%0d", i), {32'd0, vout}, 64'd1 << i);
            chk($sformatf("t3_data_%0d", i), {56'd0, dout[i*8 +: 8]}, 64'(i));
        end
        vin = 1'b0;
        tick();
        chk("t3_empty", {32'd0, vout}, 64'd0);
        chk("t3_cnt_ch2", {60'd0, cnt}, {60'd0, cexp(1)});
        chk("t3_no_err32", {63'd0, err}, 64'd0);

        // 4: out-of-range select on the 24-channel instance
        tick();
        vin = 1'b1; sel = 5'd25; din = 8'h3C;
        #1 chk("t4_ready24", {63'd0, rdy_o24}, 64'd1);
        tick();
        chk("t4_err24", {63'd0, err24}, 64'd1);
        chk("t4_vout24", {40'd0, vout24}, 64'd0);
        vin = 1'b0;
        tick();
        chk("t4_err24_clear", {63'd0, err24}, 64'd0);
        chk("t4_vout24_idle", {40'd0, vout24}, 64'd0);

        // 5: enable low and reset while channel 9 is stalled
        rdy[9] = 1'b0; vin = 1'b1; sel = 5'd9; din = 8'h77;
        tick();
        chk("t5_v9", {32'd0, vout}, 64'h200);
        chk("t5_d9", {56'd0, dout[79:72]}, 64'h77);
        en = 1'b0; sel = 5'd4;
        #1 chk("t5_ready_disabled", {63'd0, rdy_o}, 64'd0);
        tick();
        chk("t5_hold_v", {32'd0, vout}, 64'h200);
        chk("t5_hold_d9", {56'd0, dout[79:72]}, 64'h77);
        rst = 1'b1;
        #1 chk("t5_ready_in_reset", {63'd0, rdy_o}, 64'd0);
        tick();
        chk("t5_reset_vout", {32'd0, vout}, 64'd0);
        chk("t5_reset_d9", {56'd0, dout[79:72]}, 64'd0);
        rst = 1'b0; en = 1'b1; vin = 1'b0; rdy[9] = 1'b1;
        tick();
        chk("t5_not_delivered", {32'd0, vout}, 64'd0);
        chk("t5_cnt_cleared", {60'd0, cnt}, 64'd0);

        // 6: 20 beats to channel 2, counter saturation
        vin = 1'b1; sel = 5'd2;
        for (int j = 0; j < 20; j++) begin
            din = 8'(j);
            tick();
            chk($sformatf("t6_cnt_%0d", j), {60'd0, cnt}, {60'd0, cexp(j)});
        end
        vin = 1'b0;
        tick();
        chk("t6_cnt_sat", {60'd0, cnt}, {60'd0, cexp(20)});
        chk("t6_cnt24_sat", {60'd0, cnt24}, {60'd0, cexp(20)});
        csel = 5'd3;
        tick();
        chk("t6_cnt_other", {60'd0, cnt}, 64'd0);
        csel = 5'd30;
        tick();
        chk("t6_cnt24_oor_sel", {60'd0, cnt24}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_1_n_stream.md
Name: demux_1_n_stream

Overview:
Parametrised, registered 1:N demultiplexer with a valid/ready stream handshake. It is the successor to the combinational 1:32 DEMUX. Each beat on the single input stream is steered by Select_In into a one-entry output register on one of NUM_CH channels. Each channel drains independently under its own backpressure. The block sits between a single producer and NUM_CH consumers in the datapath.

Parameters:
NUM_CH, 32, number of output channels (2..64; need not be a power of 2).
DATA_W, 8, data width per beat.
CNT_W, 16, width of per-channel beat counters (optional feature only).
SEL_W (localparam), $clog2(NUM_CH), width of Select_In.

Ports:
Clock_In  input  1  single clock, rising edge.
Reset_In  input  1  synchronous, active-high reset.
Enable_In  input  1  when 0, no new beats are accepted; outputs still drain.
Valid_In  input  1  input beat valid.
Ready_Out  output  1  block can accept the input beat this cycle.
Data_In  input  DATA_W  input beat data.
Select_In  input  SEL_W  destination channel, sampled with the beat.
Valid_Out  output  NUM_CH  per-channel output valid.
Ready_In  input  NUM_CH  per-channel consumer ready.
Data_Out  output  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
Error_Out  output  1  one-cycle pulse when a beat with Select_In >= NUM_CH is accepted.
Count_Select_In  input  SEL_W  channel whose counter is shown on Count_Out.
Count_Out  output  CNT_W  beat count of the selected channel.

Behaviour:
- Reset (Reset_In=1 at a clock edge) sets:
  - Valid_Out = 0, Data_Out = 0, Error_Out = 0, all counters = 0.
  - Ready_Out is forced to 0 while Reset_In = 1.
- Reset mid-operation: buffered beats are discarded and not delivered.
- Ready_Out is combinational:
  - Ready_Out = !Reset_In && Enable_In && (Select_In >= NUM_CH || !Valid_Out[Select_In] || Ready_In[Select_In]).
  - This creates a combinational Ready_In -> Ready_Out path; this is intentional.
- Accept when Valid_In && Ready_Out.
  - On the next edge, channel Select_In loads Data_In and Valid_Out[Select_In] becomes 1.
  - Latency is 1 cycle, input beat to Valid_Out.
- Channel drain: Valid_Out[k] && Ready_In[k] completes the transfer.
  - Valid_Out[k] clears on the next edge unless the channel is reloaded in the same cycle.
- Channel stall: while Valid_Out[k] && !Ready_In[k], Data_Out[k] holds stable and Valid_Out[k] stays 1.
- Simultaneous drain and load on the same channel: the new beat is loaded and Valid_Out[k] stays 1. Full throughput is 1 beat/cycle per channel.
- Channels other than Select_In are unaffected by an accept. All channels drain concurrently.
- Out-of-range select (Select_In >= NUM_CH, possible only when NUM_CH is not a power of 2):
  - The beat is accepted (Ready_Out = Enable_In) and dropped.
  - Error_Out = 1 for exactly the following cycle. No channel changes.
- Enable_In = 0: Ready_Out = 0 and no loads occur. Pending Valid_Out still drain normally.
- Valid_In = 0: Select_In and Data_In are ignored. Error_Out = 0 next cycle.
- Data_Out[k] is undefined to the consumer when Valid_Out[k] = 0; RTL keeps the last value.

Optional Feature:
DEMUX_BEAT_COUNT_EN
- Defined:
  - Each channel has a CNT_W-bit counter incremented on every accepted beat routed to it.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - Count_Out is registered and equals the count of channel Count_Select_In as of the previous edge, with 1-cycle latency.
  - Count_Select_In >= NUM_CH gives Count_Out = 0.
- Not defined:
  - No counter logic is built.
  - Count_Out is tied to 0 and Count_Select_In is ignored. The ports always exist.

Test Plan:
1. Reset then stream: Reset_In=1 for 2 cycles, then Enable_In=1, Valid_In=1, Select_In=5, Data_In=0xA5, Ready_In=all 1 -> next cycle Valid_Out[5]=1, Data_Out[47:40]=0xA5, all other Valid_Out=0; Valid_Out[5]=0 the cycle after Valid_In drops.
2. Backpressure: Ready_In[3]=0, send 0x11 then 0x22 to channel 3 -> 0x11 is held on channel 3 and Ready_Out=0 while Select_In=3. Beat 0x22 is sent to channel 7 in the same stall window -> accepted. Raise Ready_In[3] -> 0x11 drains, then 0x22 is accepted to channel 3, with no loss or duplication.
3. Back-to-back throughput: 32 consecutive beats with Select_In=0..31, Data_In=index, all Ready_In=1 -> Ready_Out=1 every cycle, each channel k shows data k exactly one cycle later.
4. Out-of-range (NUM_CH=24): Valid_In=1, Select_In=25, Data_In=0x3C -> Ready_Out=1, Error_Out=1 for one cycle, Valid_Out remains 0.
5. Enable and reset mid-operation: channel 9 holding 0x77 with Ready_In[9]=0; Enable_In=0 -> Ready_Out=0 and channel 9 still holds. Then Reset_In=1 -> Valid_Out=0, 0x77 is never delivered.
6. With DEMUX_BEAT_COUNT_EN, CNT_W=4: send 20 beats to channel 2, Count_Select_In=2 -> Count_Out saturates at 15. Counts on other channels stay 0. Without the macro, Count_Out=0 throughout.
